load_store_unit: RTL and testbench

- Initiator side of the CPU data-memory interface. Sits between the execute/memory stage and the word-organised data memory.
- Accepts byte, halfword and word load/store requests. Drives word-aligned memory accesses and performs read-modify-write for sub-word stores.
- Extracts and sign/zero-extends load data and flags misaligned or out-of-range accesses.
- Multi-cycle: the core stalls on ready=0.

---
 rtl/load_store_unit_if.sv | 29 ++
 rtl/load_store_unit.sv | 130 +++++++++++++
 tb/tb_load_store_unit.sv | 295 +++++++++++++++++++++++++++++
 3 files changed

// File: rtl/load_store_unit_if.sv
// Core/memory bus bundle for the load/store unit: request handshake on one side,
// word-organised data memory port on the other.
interface load_store_unit_if;
    logic        req;
    logic        is_store;
    logic [1:0]  size;
    logic        unsigned_ld;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic        ready;
    logic        done;
    logic        fault;
    logic [31:0] rdata;
    logic [31:0] mem_address;
    logic [31:0] mem_write_data;
    logic [31:0] mem_read_data;
    logic        mem_write;
    logic        mem_read;

    modport master (
        output req, is_store, size, unsigned_ld, addr, wdata, mem_read_data,
        input  ready, done, fault, rdata, mem_address, mem_write_data, mem_write, mem_read
    );

    modport slave (
        input  req, is_store, size, unsigned_ld, addr, wdata, mem_read_data,
        output ready, done, fault, rdata, mem_address, mem_write_data, mem_write, mem_read
    );
endinterface

// File: rtl/load_store_unit.sv
// Load/store unit: word-aligned memory accesses, read-modify-write for sub-word
// stores, sign/zero extension of loads and misalignment/range fault detection.
module load_store_unit #(
    parameter int unsigned MEM_BYTES = 4096,
    parameter int unsigned DATA_W    = 32
) (
    input  logic             clk_i,
    input  logic             rst_ni,
    load_store_unit_if.slave lsu
);

    typedef enum logic [2:0] {IDLE, LOAD, RMW_RD, WRITE, DONE} state_e;

    state_e              state_q, state_d;
    logic [1:0]          lane_q;
    logic [1:0]          size_q;
    logic                unsigned_q;
    logic                fault_q, fault_d;
    logic [15:0]         wdata_q;
    logic                ready_q, done_q, fault_out_q, mem_read_q, mem_write_q;
    logic [DATA_W-1:0]   rdata_q, mem_address_q, mem_write_data_q;

    logic                accept;
    logic                is_word;
    logic                req_fault;
    logic [7:0]          byte_v;
    logic [15:0]         half_v;
    logic [DATA_W-1:0]   load_ext;
    logic [DATA_W-1:0]   merged;

    // Size 11 decodes as a word, so bit 1 alone marks a word access.
    always_comb begin
        accept    = (state_q == IDLE) && lsu.req;
        is_word   = lsu.size[1];
        req_fault = ((lsu.size == 2'b01) && lsu.addr[0])
                  || (is_word && (lsu.addr[1:0] != 2'b00))
                  || (lsu.addr >= 32'(MEM_BYTES));
        fault_d   = accept ? req_fault : fault_q;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE: begin
                if (lsu.req) begin
                    if (req_fault)          state_d = DONE;
                    else if (!lsu.is_store) state_d = LOAD;
                    else if (is_word)       state_d = WRITE;
                    else                    state_d = RMW_RD;
                end
            end
            LOAD:    state_d = DONE;
            RMW_RD:  state_d = WRITE;
            WRITE:   state_d = DONE;
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Lane extraction for loads and lane merge for the read-modify-write path.
    always_comb begin
        byte_v   = lsu.mem_read_data[{lane_q, 3'b000} +: 8];
        half_v   = lsu.mem_read_data[{lane_q[1], 4'b0000} +: 16];
        load_ext = lsu.mem_read_data;
        merged   = lsu.mem_read_data;
        case (size_q)
            2'b00: begin
                load_ext = unsigned_q ? {24'b0, byte_v} : {{24{byte_v[7]}}, byte_v};
                merged[{lane_q, 3'b000} +: 8] = wdata_q[7:0];
            end
            2'b01: begin
                load_ext = unsigned_q ? {16'b0, half_v} : {{16{half_v[15]}}, half_v};
                merged[{lane_q[1], 4'b0000} +: 16] = wdata_q;
            end
            default: ;
        endcase
    end

    // Outputs are registered from the next state so they change only at an edge,
    // except reset, which clears them (and drops mem_write) immediately.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q          <= IDLE;
            lane_q           <= 2'b00;
            size_q           <= 2'b00;
            unsigned_q       <= 1'b0;
            fault_q          <= 1'b0;
            wdata_q          <= '0;
            ready_q          <= 1'b1;
            done_q           <= 1'b0;
            fault_out_q      <= 1'b0;
            mem_read_q       <= 1'b0;
            mem_write_q      <= 1'b0;
            rdata_q          <= '0;
            mem_address_q    <= '0;
            mem_write_data_q <= '0;
        end else begin
            state_q     <= state_d;
            fault_q     <= fault_d;
            ready_q     <= (state_d == IDLE);
            done_q      <= (state_d == DONE);
            fault_out_q <= (state_d == DONE) && fault_d;
            mem_read_q  <= (state_d == LOAD) || (state_d == RMW_RD);
            mem_write_q <= (state_d == WRITE);
            if (accept) begin
                lane_q        <= lsu.addr[1:0];
                size_q        <= lsu.size;
                unsigned_q    <= lsu.unsigned_ld;
                wdata_q       <= lsu.wdata[15:0];
                mem_address_q <= {lsu.addr[31:2], 2'b00};
                if (is_word && lsu.is_store && !req_fault)
                    mem_write_data_q <= lsu.wdata;
            end
            if (state_q == LOAD)
                rdata_q <= load_ext;
            if (state_q == RMW_RD)
                mem_write_data_q <= merged;
        end
    end

    assign lsu.ready          = ready_q;
    assign lsu.done           = done_q;
    assign lsu.fault          = fault_out_q;
    assign lsu.rdata          = rdata_q;
    assign lsu.mem_address    = mem_address_q;
    assign lsu.mem_write_data = mem_write_data_q;
    assign lsu.mem_read       = mem_read_q;
    assign lsu.mem_write      = mem_write_q;

endmodule

// File: tb/tb_load_store_unit.sv
// Testbench for load_store_unit: directed scenarios plus random traffic checked
// against a byte-array memory model.
module tb_load_store_unit;

    logic clk;
    logic rst_n;

    load_store_unit_if bus();

    load_store_unit #(.MEM_BYTES(4096), .DATA_W(32)) dut (
        .clk_i  (clk),
        .rst_ni (rst_n),
        .lsu    (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Word memory seen by the DUT, with a backdoor port for preloading.
    logic [31:0] mem [0:1023];
    logic        bdEn;
    logic [9:0]  bdAddr;
    logic [31:0] bdData;

    always @(posedge clk) begin
        if (bus.mem_write)
            mem[bus.mem_address[11:2]] <= bus.mem_write_data;
        else if (bdEn)
            mem[bdAddr] <= bdData;
    end

    assign bus.mem_read_data = mem[bus.mem_address[11:2]];

    int writeCount = 0;
    int readCount = 0;
    int doneCount = 0;
    int bothCount = 0;
    logic [31:0] lastWriteAddr = 32'h0;

    always @(negedge clk) begin
        if (bus.mem_write) begin
            writeCount++;
            lastWriteAddr = bus.mem_address;
        end
        if (bus.mem_read) readCount++;
        if (bus.done) doneCount++;
        if (bus.mem_read && bus.mem_write) bothCount++;
    end

    // Reference model: byte-addressed memory and the expected held load result.
    logic [7:0]  refMem [0:4095];
    logic [31:0] expRdata;

    int assertCount = 0;
    int failCount = 0;

    function automatic int sizeBytes(input logic [1:0] sz);
        return (sz == 2'd0) ? 1 : (sz == 2'd1) ? 2 : 4;
    endfunction

    function automatic logic [31:0] refLoad(input logic [31:0] a, input logic [1:0] sz, input logic uns);
        logic [31:0] v;
        int n;
        n = sizeBytes(sz);
        v = 32'h0;
        for (int i = 0; i < n; i++)
            v = v | ({24'h0, refMem[int'(a) + i]} << (8 * i));
        if (!uns && n < 4 && v[8 * n - 1])
            v = v | ~((32'd1 << (8 * n)) - 32'd1);
        return v;
    endfunction

    function automatic logic [31:0] refWord(input int idx);
        return {refMem[4 * idx + 3], refMem[4 * idx + 2], refMem[4 * idx + 1], refMem[4 * idx]};
    endfunction

    function automatic logic refFault(input logic [31:0] a, input logic [1:0] sz);
        return (sz == 2'd1 && a % 2 != 0) || (sz >= 2'd2 && a % 4 != 0) || (a >= 32'd4096);
    endfunction

    task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        assertCount++;
        assert (obs === exp) else begin
            failCount++;
            $error("[TB] FAIL %s: observed=0x%08h expected=0x%08h", tag, obs, exp);
        end
    endtask

    task automatic waitReady();
        int waitCnt;
        waitCnt = 0;
        @(negedge clk);
        while (!bus.ready && waitCnt < 20) begin
            @(negedge clk);
            waitCnt++;
        end
        checkOutput("ready_wait", {31'b0, bus.ready}, 32'd1);
    endtask

    task automatic driveReq(input logic st, input logic [1:0] sz, input logic uns,
                            input logic [31:0] a, input logic [31:0] wd);
        bus.req         = 1'b1;
        bus.is_store    = st;
        bus.size        = sz;
        bus.unsigned_ld = uns;
        bus.addr        = a;
        bus.wdata       = wd;
    endtask

    // One complete request, checked against the model on completion.
    task automatic applyStimulus(input logic st, input logic [1:0] sz, input logic uns,
                                 input logic [31:0] a, input logic [31:0] wd);
        int lat, wr0, rd0, expLat, expWr, expRd, n;
        logic expFault;
        waitReady();
        wr0 = writeCount;
        rd0 = readCount;
        driveReq(st, sz, uns, a, wd);
        @(posedge clk);
        #1;
        bus.req = 1'b0;
        lat = 1;
        while (!bus.done && lat < 10) begin
            @(posedge clk);
            #1;
            lat++;
        end
        expFault = refFault(a, sz);
        n = sizeBytes(sz);
        if (expFault)      expLat = 1;
        else if (!st)      expLat = 2;
        else if (n == 4)   expLat = 2;
        else               expLat = 3;
        expWr = (st && !expFault) ? 1 : 0;
        expRd = (!expFault && (!st || n < 4)) ? 1 : 0;
        if (!expFault) begin
            if (st) begin
                for (int i = 0; i < n; i++)
                    refMem[int'(a) + i] = wd[8 * i +: 8];
            end else begin
                expRdata = refLoad(a, sz, uns);
            end
        end
        checkOutput("done_seen", {31'b0, bus.done}, 32'd1);
        checkOutput("latency", lat, expLat);
        checkOutput("fault", {31'b0, bus.fault}, {31'b0, expFault});
        checkOutput("rdata", bus.rdata, expRdata);
        checkOutput("write_pulses", writeCount - wr0, expWr);
        checkOutput("read_cycles", readCount - rd0, expRd);
        if (expWr == 1)
            checkOutput("write_addr", lastWriteAddr, a & 32'hFFFF_FFFC);
        if (a < 32'd4096)
            checkOutput("mem_word", mem[a[11:2]], refWord(int'(a[11:2])));
    endtask

    initial begin
        #1_000_000;
        $display("[TB] FAIL watchdog: simulation did not finish in time");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        int wr0, d0;
        logic [31:0] a, wd;
        logic [1:0] sz;

        rst_n = 1'b0;
        bdEn = 1'b0;
        bdAddr = '0;
        bdData = '0;
        expRdata = 32'h0;
        driveReq(1'b0, 2'b00, 1'b0, 32'h0, 32'h0);
        bus.req = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        checkOutput("rst_ready", {31'b0, bus.ready}, 32'd1);
        checkOutput("rst_done", {31'b0, bus.done}, 32'd0);
        checkOutput("rst_fault", {31'b0, bus.fault}, 32'd0);
        checkOutput("rst_rdata", bus.rdata, 32'h0);
        checkOutput("rst_mem_address", bus.mem_address, 32'h0);
        checkOutput("rst_mem_wdata", bus.mem_write_data, 32'h0);
        checkOutput("rst_mem_read", {31'b0, bus.mem_read}, 32'd0);
        checkOutput("rst_mem_write", {31'b0, bus.mem_write}, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;

        $display("[TB] preloading memory");
        for (int i = 0; i < 1024; i++) begin
            @(negedge clk);
            bdEn = 1'b1;
            bdAddr = 10'(i);
            bdData = (i == 8) ? 32'h8077_66F0 : (i == 12) ? 32'h1122_3344 : $urandom;
            for (int b = 0; b < 4; b++)
                refMem[4 * i + b] = bdData[8 * b +: 8];
        end
        @(negedge clk);
        bdEn = 1'b0;

        $display("[TB] word store then load");
        applyStimulus(1'b1, 2'b10, 1'b0, 32'h10, 32'hDEAD_BEEF);
        applyStimulus(1'b0, 2'b10, 1'b0, 32'h10, 32'h0);
        checkOutput("tp_word_load", bus.rdata, 32'hDEAD_BEEF);

        $display("[TB] byte loads with extension");
        applyStimulus(1'b0, 2'b00, 1'b0, 32'h23, 32'h0);
        checkOutput("tp_byte_signed", bus.rdata, 32'hFFFF_FF80);
        applyStimulus(1'b0, 2'b00, 1'b1, 32'h23, 32'h0);
        checkOutput("tp_byte_unsigned", bus.rdata, 32'h0000_0080);
        applyStimulus(1'b0, 2'b00, 1'b0, 32'h21, 32'h0);
        checkOutput("tp_byte_pos", bus.rdata, 32'h0000_0066);
        applyStimulus(1'b0, 2'b01, 1'b0, 32'h22, 32'h0);
        checkOutput("tp_half_signed", bus.rdata, 32'hFFFF_8077);

        $display("[TB] sub-word read-modify-write");
        applyStimulus(1'b1, 2'b00, 1'b0, 32'h31, 32'h0000_00AB);
        checkOutput("tp_rmw_byte", mem[12], 32'h1122_AB44);
        applyStimulus(1'b1, 2'b01, 1'b0, 32'h32, 32'h0000_CDEF);
        checkOutput("tp_rmw_half", mem[12], 32'hCDEF_AB44);

        $display("[TB] faults");
        applyStimulus(1'b0, 2'b01, 1'b0, 32'h41, 32'h0);
        applyStimulus(1'b0, 2'b10, 1'b0, 32'h42, 32'h0);
        applyStimulus(1'b1, 2'b10, 1'b0, 32'h1000, 32'h1234_5678);
        applyStimulus(1'b1, 2'b11, 1'b0, 32'h46, 32'h1234_5678);
        applyStimulus(1'b0, 2'b00, 1'b1, 32'hFFF, 32'h0);
        applyStimulus(1'b0, 2'b10, 1'b0, 32'hFFC, 32'h0);

        $display("[TB] reset during read-modify-write");
        waitReady();
        wr0 = writeCount;
        driveReq(1'b1, 2'b00, 1'b0, 32'h50, 32'h0000_005A);
        @(posedge clk);
        #1;
        bus.req = 1'b0;
        checkOutput("rmw_rd_read", {31'b0, bus.mem_read}, 32'd1);
        #2;
        rst_n = 1'b0;
        #1;
        expRdata = 32'h0;
        checkOutput("mid_rst_ready", {31'b0, bus.ready}, 32'd1);
        checkOutput("mid_rst_mem_read", {31'b0, bus.mem_read}, 32'd0);
        checkOutput("mid_rst_mem_write", {31'b0, bus.mem_write}, 32'd0);
        checkOutput("mid_rst_done", {31'b0, bus.done}, 32'd0);
        checkOutput("mid_rst_mem_address", bus.mem_address, 32'h0);
        checkOutput("mid_rst_rdata", bus.rdata, 32'h0);
        @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        checkOutput("post_rst_ready", {31'b0, bus.ready}, 32'd1);
        checkOutput("post_rst_no_write", writeCount - wr0, 32'd0);
        checkOutput("post_rst_mem", mem[20], refWord(20));

        $display("[TB] request while busy");
        waitReady();
        driveReq(1'b0, 2'b10, 1'b0, 32'h10, 32'h0);
        @(posedge clk);
        #1;
        d0 = doneCount;
        driveReq(1'b1, 2'b10, 1'b0, 32'h44, 32'hAAAA_5555);
        @(posedge clk);
        #1;
        bus.req = 1'b0;
        expRdata = refLoad(32'h10, 2'b10, 1'b0);
        checkOutput("busy_done", {31'b0, bus.done}, 32'd1);
        checkOutput("busy_rdata", bus.rdata, expRdata);
        repeat (4) @(negedge clk);
        checkOutput("busy_done_count", doneCount - d0, 32'd1);
        checkOutput("busy_mem_address", bus.mem_address, 32'h10);
        checkOutput("busy_mem_untouched", mem[17], refWord(17));

        $display("[TB] random traffic");
        for (int k = 0; k < 120; k++) begin
            sz = 2'($urandom_range(0, 3));
            case ($urandom_range(0, 9))
                0:       a = 32'h1000 + 32'($urandom_range(0, 255));
                1:       a = $urandom;
                default: a = 32'($urandom_range(0, 4095));
            endcase
            if ($urandom_range(0, 3) != 0) begin
                if (sz == 2'd1)      a = a & 32'hFFFF_FFFE;
                else if (sz >= 2'd2) a = a & 32'hFFFF_FFFC;
            end
            wd = $urandom;
            applyStimulus(1'($urandom_range(0, 1)), sz, 1'($urandom_range(0, 1)), a, wd);
        end

        checkOutput("read_write_exclusive", bothCount, 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", assertCount, failCount);
        $finish;
    end

endmodule
